// File: rtl/uart_rx_if.sv
// uart_rx_if: bundle of the serial input and receive-side outputs of uart_rx.
//
// Signals:
//   i_rx_serial     serial line into the receiver (idle high)
//   o_rx_dv         one-cycle pulse, o_rx_byte holds a new byte
//   o_rx_byte       last correctly received byte
//   o_rx_active     high while a frame is being received
//   o_rx_frame_err  one-cycle pulse, stop bit sampled low
//   o_rx_parity_err one-cycle pulse, parity mismatch (only with UART_RX_PARITY_EN)
//
// Modports:
//   master  the receiver itself (drives the o_* outputs)
//   slave   the line driver / byte consumer
//
// Optional feature macro: UART_RX_PARITY_EN
interface uart_rx_if;
  logic       i_rx_serial;
  logic       o_rx_dv;
  logic [7:0] o_rx_byte;
  logic       o_rx_active;
  logic       o_rx_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       o_rx_parity_err;

  modport master (
    input  i_rx_serial,
    output o_rx_dv, o_rx_byte, o_rx_active, o_rx_frame_err, o_rx_parity_err
  );
  modport slave (
    output i_rx_serial,
    input  o_rx_dv, o_rx_byte, o_rx_active, o_rx_frame_err, o_rx_parity_err
  );
`else
  modport master (
    input  i_rx_serial,
    output o_rx_dv, o_rx_byte, o_rx_active, o_rx_frame_err
  );
  modport slave (
    output i_rx_serial,
    input  o_rx_dv, o_rx_byte, o_rx_active, o_rx_frame_err
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, counterpart of uart_tx. The serial line is
// double-flopped, the start bit is confirmed at mid-bit, and every following
// bit is sampled one full bit period later, i.e. at its middle.
//
// Parameters:
//   clks_per_bit  i_clock frequency / baud rate (4..65535)
//
// Ports:
//   i_clock    system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        uart_rx_if.master: i_rx_serial in; o_rx_dv, o_rx_byte,
//              o_rx_active, o_rx_frame_err (and o_rx_parity_err) out
//
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit; a mismatch pulses o_rx_parity_err and
// suppresses o_rx_dv.
module uart_rx #(
  parameter int unsigned clks_per_bit = 87
) (
  input  logic     i_clock,
  input  logic     i_reset_n,
  uart_rx_if.master bus
);

  localparam logic [15:0] half_count = 16'((clks_per_bit - 1) / 2);
  localparam logic [15:0] last_count = 16'(clks_per_bit - 1);

  typedef enum logic [2:0] {
    s_idle,
    s_rx_start_bit,
    s_rx_data_bits,
`ifdef UART_RX_PARITY_EN
    s_rx_parity_bit,
`endif
    s_rx_stop_bit,
    s_cleanup
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta, r_rx;
  logic [15:0] count_q, count_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        frame_err_q, frame_err_d;
  logic        active_q, active_d;
`ifdef UART_RX_PARITY_EN
  logic        parity_bad_q, parity_bad_d;
  logic        parity_err_q, parity_err_d;
`endif

  // Two-flop synchronizer; both flops reset to the idle-high line level so
  // reset release never looks like a start bit.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_meta <= 1'b1;
      r_rx    <= 1'b1;
    end else begin
      rx_meta <= bus.i_rx_serial;
      r_rx    <= rx_meta;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= s_idle;
      count_q      <= '0;
      bit_index_q  <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      dv_q         <= 1'b0;
      frame_err_q  <= 1'b0;
      active_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      bit_index_q  <= bit_index_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      dv_q         <= dv_d;
      frame_err_q  <= frame_err_d;
      active_q     <= active_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state and output logic. The pulses default low so they last
  // exactly the one cycle spent in s_cleanup.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    bit_index_d  = bit_index_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    dv_d         = 1'b0;
    frame_err_d  = 1'b0;
    active_d     = active_q;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      s_idle: begin
        count_d     = '0;
        bit_index_d = '0;
        if (!r_rx) begin
          state_d  = s_rx_start_bit;
          active_d = 1'b1;
        end
      end

      // A start bit that is high again at mid-bit was a glitch.
      s_rx_start_bit: begin
        if (count_q == half_count) begin
          count_d = '0;
          if (!r_rx) begin
            state_d = s_rx_data_bits;
          end else begin
            state_d  = s_idle;
            active_d = 1'b0;
          end
        end else begin
          count_d = count_q + 16'd1;
        end
      end

      s_rx_data_bits: begin
        if (count_q == last_count) begin
          count_d              = '0;
          shift_d[bit_index_q] = r_rx;
          if (bit_index_q == 3'd7) begin
            bit_index_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d     = s_rx_parity_bit;
`else
            state_d     = s_rx_stop_bit;
`endif
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          count_d = count_q + 16'd1;
        end
      end

`ifdef UART_RX_PARITY_EN
      // Even parity: the received bit must equal the XOR of the data bits.
      s_rx_parity_bit: begin
        if (count_q == last_count) begin
          count_d      = '0;
          parity_bad_d = (r_rx != ^shift_q);
          state_d      = s_rx_stop_bit;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
`endif

      s_rx_stop_bit: begin
        if (count_q == last_count) begin
          count_d = '0;
          state_d = s_cleanup;
`ifdef UART_RX_PARITY_EN
          parity_err_d = parity_bad_q;
          if (r_rx && !parity_bad_q) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else if (!r_rx) begin
            frame_err_d = 1'b1;
          end
`else
          if (r_rx) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
`endif
        end else begin
          count_d = count_q + 16'd1;
        end
      end

      s_cleanup: begin
        state_d  = s_idle;
        active_d = 1'b0;
      end

      default: begin
        state_d  = s_idle;
        active_d = 1'b0;
      end
    endcase
  end

  assign bus.o_rx_dv         = dv_q;
  assign bus.o_rx_byte       = byte_q;
  assign bus.o_rx_active     = active_q;
  assign bus.o_rx_frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.o_rx_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at clks_per_bit = 16. Stimulus
// pushes the expected pulse (byte, framing error or parity error) before
// sending each frame; a monitor pops and compares whenever the receiver
// pulses. Also checks reset values, o_rx_active duration and byte hold.
module tb_uart_rx;

  localparam int CPB = 16;

  localparam logic [1:0] K_DV   = 2'd0;
  localparam logic [1:0] K_FERR = 2'd1;
  localparam logic [1:0] K_PERR = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic i_clock = 1'b0;
  logic i_reset_n;

  uart_rx_if bus ();

  uart_rx #(.clks_per_bit(CPB)) dut (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 i_clock = ~i_clock;

  exp_t exp_q[$];
  int   compares = 0;
  int   fails    = 0;
  int   run_len  = 0;
  int   last_run = 0;

  logic perr_now;
`ifdef UART_RX_PARITY_EN
  assign perr_now = bus.o_rx_parity_err;
`else
  assign perr_now = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compares++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual,
                            input int lo, input int hi);
    compares++;
    if (actual < lo || actual > hi) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge i_clock);
  endtask

  task automatic sendBits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.i_rx_serial = frame[i];
      repeat (CPB) @(negedge i_clock);
    end
    bus.i_rx_serial = 1'b1;
  endtask

  // One frame with the given stop-bit level (and correct parity if enabled).
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
`ifdef UART_RX_PARITY_EN
    sendBits({stop_bit, ^data, data, 1'b0}, 11);
`else
    sendBits({1'b0, stop_bit, data, 1'b0}, 10);
`endif
  endtask

  task automatic pushExp(input logic [1:0] kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every pulse against the scoreboard and tracks how
  // long o_rx_active stays high.
  always @(negedge i_clock) begin
    logic [1:0] kind_now;
    exp_t e;
    if (bus.o_rx_dv || bus.o_rx_frame_err || perr_now) begin
      checkOutput("dv_ferr_exclusive", {31'd0, bus.o_rx_dv & bus.o_rx_frame_err}, 32'd0);
      kind_now = bus.o_rx_dv ? K_DV : (bus.o_rx_frame_err ? K_FERR : K_PERR);
      if (exp_q.size() == 0) begin
        compares++;
        fails++;
        $display("[TB] FAIL unexpected_pulse: got kind %0d, expected none", kind_now);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pulse_kind", {30'd0, kind_now}, {30'd0, e.kind});
        if (e.kind == K_DV)
          checkOutput("rx_byte", {24'd0, bus.o_rx_byte}, {24'd0, e.data});
      end
    end
    if (bus.o_rx_active) begin
      run_len++;
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  initial begin
    logic [7:0] abort_byte;
    bus.i_rx_serial = 1'b1;
    i_reset_n = 1'b0;
    idle(3);
    $display("[TB] reset values");
    checkOutput("reset_dv",     {31'd0, bus.o_rx_dv},        32'd0);
    checkOutput("reset_byte",   {24'd0, bus.o_rx_byte},      32'd0);
    checkOutput("reset_active", {31'd0, bus.o_rx_active},    32'd0);
    checkOutput("reset_ferr",   {31'd0, bus.o_rx_frame_err}, 32'd0);
    i_reset_n = 1'b1;
    idle(5);

    $display("[TB] single frame 0xA5");
    pushExp(K_DV, 8'hA5);
    applyStimulus(8'hA5, 1'b1);
    idle(2 * CPB);
    checkRange("active_len", last_run, 150, 156);

    $display("[TB] framing error on 0x3C");
    pushExp(K_FERR, 8'h00);
    applyStimulus(8'h3C, 1'b0);
    idle(2 * CPB);
    checkOutput("byte_held", {24'd0, bus.o_rx_byte}, 32'h0000_00A5);

    $display("[TB] back-to-back 0x00, 0xFF");
    pushExp(K_DV, 8'h00);
    pushExp(K_DV, 8'hFF);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    idle(2 * CPB);

    $display("[TB] 4-cycle glitch");
    bus.i_rx_serial = 1'b0;
    idle(4);
    bus.i_rx_serial = 1'b1;
    idle(3 * CPB);
    checkRange("glitch_active_len", last_run, 1, 12);

    $display("[TB] reset during data bit 3 of 0x55");
    abort_byte = 8'h55;
    bus.i_rx_serial = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      bus.i_rx_serial = abort_byte[i];
      idle(CPB);
    end
    bus.i_rx_serial = abort_byte[3];
    idle(CPB / 2);
    i_reset_n = 1'b0;
    idle(2);
    checkOutput("abort_dv",     {31'd0, bus.o_rx_dv},     32'd0);
    checkOutput("abort_byte",   {24'd0, bus.o_rx_byte},   32'd0);
    checkOutput("abort_active", {31'd0, bus.o_rx_active}, 32'd0);
    bus.i_rx_serial = 1'b1;
    idle(2);
    i_reset_n = 1'b1;
    idle(2 * CPB);
    pushExp(K_DV, 8'hC3);
    applyStimulus(8'hC3, 1'b1);
    idle(2 * CPB);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity frames");
    pushExp(K_DV, 8'h07);
    sendBits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    idle(2 * CPB);
    pushExp(K_PERR, 8'h00);
    sendBits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
    idle(2 * CPB);
    checkOutput("parity_byte_held", {24'd0, bus.o_rx_byte}, 32'h0000_0007);
`endif

    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
